// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two sram-like masters (inst, data) sharing one sram-like
// slave port. Data has priority; a stalled request keeps the grant until the
// slave accepts it. Accepted request sources are queued in order so that each
// returning data_ok is routed back to the master that issued it.
`timescale 1ns/1ps
module sram_like_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // slave port
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  logic [DEPTH-1:0] tag_q, tag_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             lock_vld_q, lock_vld_d;
  logic             lock_src_q, lock_src_d;

  logic grant;
  logic grant_req;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = tag_q[rd_ptr_q];

  // Grant selection: a stalled request owns the bus, otherwise data wins.
  always_comb begin
    grant = SRC_INST;
    if (lock_vld_q)    grant = lock_src_q;
    else if (data_req) grant = SRC_DATA;
    else if (inst_req) grant = SRC_INST;
    grant_req = (grant == SRC_DATA) ? data_req : inst_req;
  end

  // Request/response handshakes and slave-side mux; all held idle in reset.
  always_comb begin
    mem_req      = !reset && grant_req && !full;
    mem_wr       = (grant == SRC_DATA) ? data_wr    : inst_wr;
    mem_size     = (grant == SRC_DATA) ? data_size  : inst_size;
    mem_addr     = (grant == SRC_DATA) ? data_addr  : inst_addr;
    mem_wdata    = (grant == SRC_DATA) ? data_wdata : inst_wdata;
    push         = mem_req && mem_addr_ok;
    pop          = !reset && mem_data_ok && !empty;
    inst_addr_ok = push && (grant == SRC_INST);
    data_addr_ok = push && (grant == SRC_DATA);
    inst_data_ok = pop && (head == SRC_INST);
    data_data_ok = pop && (head == SRC_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  // Next-state for the tag FIFO and the grant lock.
  always_comb begin
    tag_d      = tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lock_vld_d = lock_vld_q;
    lock_src_d = lock_src_q;
    if (push) begin
      tag_d[wr_ptr_q] = grant;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push) begin
      lock_vld_d = 1'b0;
    end else if (mem_req) begin
      lock_vld_d = 1'b1;
      lock_src_d = grant;
    end
  end

  // State registers; reset empties the FIFO and drops in-flight tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_vld_q <= 1'b0;
      lock_src_q <= SRC_INST;
    end else begin
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lock_vld_q <= lock_vld_d;
      lock_src_q <= lock_src_d;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level model (queue of outstanding sources).
`timescale 1ns/1ps
module tb_sram_like_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  hs;

  sram_like_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  assign hs = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

  int errors = 0;
  int checks = 0;

  // Reference model: sources of accepted-but-unanswered requests, oldest
  // first (0 = inst, 1 = data), and the master currently stalled on the bus.
  int q[$];
  int owner;

  int          exp_grant;
  logic        exp_mem_req, exp_iao, exp_dao, exp_ido, exp_ddo;
  logic [4:0]  exp_hs;
  logic        exp_wr;
  logic [1:0]  exp_size;
  logic [31:0] exp_addr, exp_wdata;

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Expected outputs for the current cycle from the model and the inputs.
  task automatic predict();
    #1;
    if (owner >= 0)    exp_grant = owner;
    else if (data_req) exp_grant = 1;
    else               exp_grant = 0;
    exp_mem_req = !reset && ((exp_grant == 1) ? data_req : inst_req) && (q.size() < DEPTH);
    exp_iao = exp_mem_req && mem_addr_ok && (exp_grant == 0);
    exp_dao = exp_mem_req && mem_addr_ok && (exp_grant == 1);
    exp_ido = !reset && mem_data_ok && ((q.size() > 0) ? (q[0] == 0) : 1'b0);
    exp_ddo = !reset && mem_data_ok && ((q.size() > 0) ? (q[0] == 1) : 1'b0);
    exp_hs  = {exp_mem_req, exp_iao, exp_dao, exp_ido, exp_ddo};
    exp_wr    = (exp_grant == 1) ? data_wr    : inst_wr;
    exp_size  = (exp_grant == 1) ? data_size  : inst_size;
    exp_addr  = (exp_grant == 1) ? data_addr  : inst_addr;
    exp_wdata = (exp_grant == 1) ? data_wdata : inst_wdata;
  endtask

  // Advance one clock and apply the predicted handshakes to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (exp_ido || exp_ddo) void'(q.pop_front());
      if (exp_iao || exp_dao) q.push_back(exp_grant);
      if (exp_mem_req && mem_addr_ok)  owner = -1;
      else if (exp_mem_req)            owner = exp_grant;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #2;
    if (hs !== 5'b0) begin
      errors++; $display("FAIL reset_hold: handshakes=%b required=00000", hs);
    end
    checks++;
    @(posedge clk); #1;
    if (dut.count_q !== '0) begin
      errors++; $display("FAIL reset_count: count=%0d required=0", dut.count_q);
    end
    checks++;
    idle(); reset = 0; q.delete(); owner = -1;
  endtask

  task automatic test_single_read();
    idle(); inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
    predict();
    if (inst_addr_ok !== 1'b1 || mem_addr !== 32'hBFC0_0000 || hs !== exp_hs) begin
      errors++; $display("FAIL single_accept: hs=%b addr=%h required hs=%b addr=bfc00000", hs, mem_addr, exp_hs);
    end
    checks++;
    tick(); idle(); predict();
    if (hs !== exp_hs) begin
      errors++; $display("FAIL single_gap: hs=%b required=%b", hs, exp_hs);
    end
    checks++;
    tick(); mem_data_ok = 1; mem_rdata = 32'h3C08_0001; predict();
    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h3C08_0001) begin
      errors++; $display("FAIL single_resp: ido=%b ddo=%b rdata=%h required 1 0 3c080001", inst_data_ok, data_data_ok, inst_rdata);
    end
    checks++;
    tick(); idle();
    if (dut.count_q !== '0) begin
      errors++; $display("FAIL single_count: count=%0d required=0", dut.count_q);
    end
    checks++;
  endtask

  task automatic test_contention();
    idle(); inst_req = 1; inst_addr = 32'h0000_1000; data_req = 1; data_addr = 32'h0000_2000; mem_addr_ok = 1;
    predict();
    if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || mem_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL contention_first: iao=%b dao=%b addr=%h required 0 1 00002000", inst_addr_ok, data_addr_ok, mem_addr);
    end
    checks++;
    tick(); data_req = 0; predict();
    if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h0000_1000 || hs !== exp_hs) begin
      errors++; $display("FAIL contention_second: iao=%b addr=%h required 1 00001000", inst_addr_ok, mem_addr);
    end
    checks++;
    tick(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_0001; predict();
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'hAAAA_0001) begin
      errors++; $display("FAIL contention_resp0: ido=%b ddo=%b required 0 1", inst_data_ok, data_data_ok);
    end
    checks++;
    tick(); mem_rdata = 32'hBBBB_0002; predict();
    if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hBBBB_0002) begin
      errors++; $display("FAIL contention_resp1: ido=%b ddo=%b required 1 0", inst_data_ok, data_data_ok);
    end
    checks++;
    tick(); idle();
  endtask

  task automatic test_lock_hold();
    logic [31:0] want;
    for (int c = 0; c < 5; c++) begin
      inst_req = (c < 4); inst_addr = 32'h0000_3000;
      data_req = (c >= 1); data_addr = 32'h0000_4000;
      mem_addr_ok = (c >= 3);
      want = (c < 4) ? 32'h0000_3000 : 32'h0000_4000;
      predict();
      if (hs !== exp_hs || mem_addr !== want) begin
        errors++; $display("FAIL lock_hold c%0d: hs=%b addr=%h required hs=%b addr=%h", c, hs, mem_addr, exp_hs, want);
      end
      checks++;
      tick();
    end
    idle(); mem_data_ok = 1;
    for (int c = 0; c < 2; c++) begin
      predict();
      if ({inst_data_ok, data_data_ok} !== ((c == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL lock_resp c%0d: ido/ddo=%b%b", c, inst_data_ok, data_data_ok);
      end
      checks++;
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    int accepted = 0;
    for (int c = 0; c < 40 && (accepted < 10 || q.size() > 0); c++) begin
      inst_req = (accepted < 10); inst_addr = 32'h0001_0000 + 32'(accepted * 4);
      mem_addr_ok = 1;
      mem_data_ok = (c == 4) || (c >= 6);
      mem_rdata = $urandom;
      predict();
      if (hs !== exp_hs || dut.count_q !== (DEPTH+1)'(q.size())) begin
        errors++; $display("FAIL full c%0d: hs=%b count=%0d required hs=%b count=%0d", c, hs, dut.count_q, exp_hs, q.size());
      end
      checks++;
      if (c == 4) begin
        if (mem_req !== 1'b0) begin
          errors++; $display("FAIL full_block: mem_req=%b required=0", mem_req);
        end
        checks++;
      end
      if (c == 5) begin
        if (inst_addr_ok !== 1'b1) begin
          errors++; $display("FAIL full_unblock: inst_addr_ok=%b required=1", inst_addr_ok);
        end
        checks++;
      end
      if (exp_iao) accepted++;
      tick();
    end
    if (accepted != 10 || q.size() != 0) begin
      errors++; $display("FAIL full_total: accepted=%0d outstanding=%0d required 10 0", accepted, q.size());
    end
    checks++;
    idle();
  endtask

  task automatic test_spurious();
    idle(); mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; predict();
    if (hs !== 5'b0) begin
      errors++; $display("FAIL spurious_ok: hs=%b required=00000", hs);
    end
    checks++;
    tick(); idle();
    if (dut.count_q !== '0) begin
      errors++; $display("FAIL spurious_count: count=%0d required=0", dut.count_q);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      idle(); inst_req = 1; inst_addr = 32'h0002_0000 + 32'(c * 4); mem_addr_ok = 1;
      predict(); tick();
    end
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    if (hs !== 5'b0) begin
      errors++; $display("FAIL reset_mid_hold: hs=%b required=00000", hs);
    end
    checks++;
    q.delete(); owner = -1;
    @(posedge clk); #1;
    idle(); reset = 0; #1;
    if (dut.count_q !== '0) begin
      errors++; $display("FAIL reset_mid_count: count=%0d required=0", dut.count_q);
    end
    checks++;
    data_req = 1; data_addr = 32'h0003_0000; mem_addr_ok = 1; predict();
    if (data_addr_ok !== 1'b1 || hs !== exp_hs) begin
      errors++; $display("FAIL reset_mid_accept: hs=%b required=%b", hs, exp_hs);
    end
    checks++;
    tick(); idle(); mem_data_ok = 1; predict();
    if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
      errors++; $display("FAIL reset_mid_resp: ido=%b ddo=%b required 0 1", inst_data_ok, data_data_ok);
    end
    checks++;
    tick(); idle();
  endtask

  task automatic test_random();
    logic ia = 1'b0;
    logic da = 1'b0;
    for (int c = 0; c < 400; c++) begin
      // Masters hold a request stable until it is accepted.
      if (!inst_req || ia) begin
        inst_req = 1'($urandom_range(0, 1)); inst_wr = 1'($urandom_range(0, 1));
        inst_size = 2'($urandom_range(0, 3)); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!data_req || da) begin
        data_req = 1'($urandom_range(0, 1)); data_wr = 1'($urandom_range(0, 1));
        data_size = 2'($urandom_range(0, 3)); data_addr = $urandom; data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 3) != 0);
      mem_data_ok = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      predict();
      if (hs !== exp_hs) begin
        errors++; $display("FAIL random_hs c%0d: hs=%b required=%b", c, hs, exp_hs);
      end
      checks++;
      if (exp_mem_req) begin
        if ({mem_wr, mem_size, mem_addr, mem_wdata} !== {exp_wr, exp_size, exp_addr, exp_wdata}) begin
          errors++; $display("FAIL random_mux c%0d: wr=%b size=%0d addr=%h wdata=%h required %b %0d %h %h",
                             c, mem_wr, mem_size, mem_addr, mem_wdata, exp_wr, exp_size, exp_addr, exp_wdata);
        end
        checks++;
      end
      if (exp_ido || exp_ddo) begin
        if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
          errors++; $display("FAIL random_rdata c%0d: inst=%h data=%h required %h", c, inst_rdata, data_rdata, mem_rdata);
        end
        checks++;
      end
      ia = exp_iao; da = exp_dao;
      tick();
    end
    idle(); mem_data_ok = 1;
    for (int c = 0; c < DEPTH + 1; c++) begin
      predict();
      if (hs !== exp_hs) begin
        errors++; $display("FAIL random_drain c%0d: hs=%b required=%b", c, hs, exp_hs);
      end
      checks++;
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); reset = 1; owner = -1;
    test_reset();
    test_single_read();
    test_contention();
    test_lock_hold();
    test_full();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master to one-slave arbiter for the sram-like bus. It sits between the CPU core's instruction and data ports and the single sram-like port of the AXI bridge. It grants one request per cycle and records the source of every accepted request in an in-order tag FIFO. It routes each returning `data_ok`/`rdata` back to the master that issued it.

## Interface
Parameters:
- `DEPTH`, 4, maximum outstanding accepted-but-unanswered requests; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst_req`, `inst_wr`  in  1  inst master request / write flag.
- `inst_size`  in  2  access size.
- `inst_addr`, `inst_wdata`  in  32  address / write data.
- `inst_rdata`  out  32  read data.
- `inst_addr_ok`, `inst_data_ok`  out  1  inst handshakes.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_rdata`, `data_addr_ok`, `data_data_ok`  same widths/directions, data master.
- `mem_req`, `mem_wr`  out  1  slave-side request / write.
- `mem_size`  out  2  slave-side size.
- `mem_addr`, `mem_wdata`  out  32  slave-side address / write data.
- `mem_rdata`  in  32  slave read data.
- `mem_addr_ok`, `mem_data_ok`  in  1  slave handshakes.

## Operation
- State:
  - tag FIFO of `DEPTH` 1-bit entries (0 = inst, 1 = data), with read/write pointers and count (width log2(DEPTH)+1);
  - `lock_vld`/`lock_src` registers.
- Grant selection, combinational:
  - if `lock_vld`, grant = `lock_src`;
  - else if `data_req`, grant data (data has priority: older instruction in MEM);
  - else if `inst_req`, grant inst.
- Slave request:
  - `mem_req` = granted master's req & !full.
  - `mem_wr/size/addr/wdata` are muxed from the granted master.
- Lock:
  - set when `mem_req` & !`mem_addr_ok`; `lock_src` = grant. Because sram-like masters hold req until addr_ok, the grant must not switch mid-request.
  - cleared on the cycle `mem_req` & `mem_addr_ok`.
- Accept:
  - `X_addr_ok` = `mem_addr_ok` & `mem_req` & grant==X.
  - The non-granted master's `addr_ok` is 0.
  - On accept, push grant into the FIFO.
- Response:
  - `X_data_ok` = `mem_data_ok` & !empty & head==X. On `mem_data_ok` & !empty, pop.
  - `inst_rdata` = `data_rdata` = `mem_rdata` (broadcast; qualified by data_ok).
- Full: `mem_req` forced 0 and no `addr_ok` is given. A pop in the same cycle does NOT unblock it; the request is granted next cycle.
- Empty with `mem_data_ok`: spurious response, dropped. No master `data_ok`, pointers unchanged.
- Simultaneous push and pop (not full, not empty): both pointers advance, count unchanged.
- Pointers wrap modulo `DEPTH`.

## Timing
- Request path (`*_req`/addr → `mem_*`, `mem_addr_ok` → `X_addr_ok`) is zero-latency combinational.
- Response routing is zero-latency combinational from `mem_data_ok`, `mem_rdata` and the FIFO head.
- FIFO/lock updates take effect at the rising edge after the handshake.
- The slave returns `data_ok` for a request no earlier than the cycle after its `addr_ok`, and in acceptance order.
- Reset, asynchronous, any time:
  - FIFO empty, `lock_vld`=0;
  - while `reset`=1, `mem_req`, all `addr_ok` and all `data_ok` are held 0;
  - any in-flight responses are discarded.
- Throughput: one accept per cycle when not full.

## Test plan
- Single inst read:
  - stimulus: `inst_req`=1, addr 0xBFC00000; slave `addr_ok` cycle 0, `data_ok` cycle 2 with rdata 0x3C080001;
  - required: `inst_addr_ok` at cycle 0, `inst_data_ok` with 0x3C080001 at cycle 2, count back to 0.
- Contention:
  - stimulus: inst and data req same cycle, slave always ready;
  - required: data granted first, inst accepted next cycle; responses routed data then inst.
- Lock hold:
  - stimulus: inst granted, slave withholds `addr_ok` 3 cycles; `data_req` rises in cycle 1;
  - required: `mem_addr` stays the inst addr until inst `addr_ok`, then data is granted.
- Full:
  - stimulus: DEPTH=4, issue 5 inst reads with no `data_ok`;
  - required: 4 accepted, `mem_req`=0 for the 5th. After one `data_ok` (pop), the 5th is accepted on the following cycle. Pointer wrap is verified over 10 requests.
- Spurious/empty:
  - stimulus: `mem_data_ok`=1 with empty FIFO;
  - required: no master `data_ok`, count stays 0.
- Reset mid-operation:
  - stimulus: assert `reset` with 3 outstanding requests;
  - required: all handshake outputs 0 immediately, count 0 after release; a new request completes normally.
